// File: rtl/fsm_arb_pkg.sv
// Shared types for the round-robin grant FSM: state encoding and the
// encoding that no legal state uses.
package fsm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } state_e;

  localparam logic [1:0] ST_ILLEGAL = 2'b11;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority pick: first set request bit scanning last+1, last+2, ...
// modulo N.
module rr_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic           found,
  output logic [IDW-1:0] idx
);

  always_comb begin
    int unsigned j;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      j = (32'(last) + k) % N;
      if (!found && req[IDW'(j)]) begin
        found = 1'b1;
        idx   = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/xz_check.sv
// Flags any X/Z on the watched bus at each rising clock edge.
module xz_check #(
  parameter int unsigned W = 1
) (
  input logic         clk,
  input logic [W-1:0] sig
);

  always_ff @(posedge clk) begin
    assert (!$isunknown(sig))
      else $error("xz_check: unknown value on watched bus");
  end

endmodule

// File: rtl/fsm_rr_arbiter.sv
// N-channel round-robin grant FSM with bounded hold and a one-cycle
// break-before-make gap. Optional FSM_RR_ARBITER_LOCK_EN adds a lock input.
module fsm_rr_arbiter
  import fsm_arb_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
`ifdef FSM_RR_ARBITER_LOCK_EN
  input  logic           lock,
`endif
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);

  state_e         r_state;
  logic [IDW-1:0] r_ptr;
  logic [HW-1:0]  r_hold;
  logic [N-1:0]   r_gnt;
  logic [IDW-1:0] r_gnt_id;
  logic           r_gnt_valid;

  logic           w_found;
  logic [IDW-1:0] w_idx;
  logic           w_at_max;
  logic           w_keep;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req   (req),
    .last  (r_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

  assign w_at_max = (r_hold == HW'(MAX_HOLD));

  // Stay in GRANT while the owner still requests and the hold budget allows.
`ifdef FSM_RR_ARBITER_LOCK_EN
  assign w_keep = req[r_ptr] && (lock || !w_at_max);
`else
  assign w_keep = req[r_ptr] && !w_at_max;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_ptr       <= IDW'(N - 1);
      r_hold      <= '0;
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state     <= GRANT;
            r_ptr       <= w_idx;
            r_hold      <= HW'(1);
            r_gnt       <= N'(1) << w_idx;
            r_gnt_id    <= w_idx;
            r_gnt_valid <= 1'b1;
          end
        end
        GRANT: begin
          if (w_keep) begin
            if (!w_at_max) r_hold <= r_hold + HW'(1);
          end else begin
            r_state     <= GAP;
            r_hold      <= '0;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
          end
        end
        GAP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state     <= IDLE;
          r_hold      <= '0;
          r_gnt       <= '0;
          r_gnt_id    <= '0;
          r_gnt_valid <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = r_gnt_valid;
  assign gnt_id    = r_gnt_id;

  xz_check #(.W(N))   u_chk_gnt   (.clk(clk), .sig(r_gnt));
  xz_check #(.W(1))   u_chk_valid (.clk(clk), .sig(r_gnt_valid));
  xz_check #(.W(IDW)) u_chk_id    (.clk(clk), .sig(r_gnt_id));

endmodule

// File: tb/tb_fsm_rr_arbiter.sv
// Directed bench for fsm_rr_arbiter (N=4, MAX_HOLD=4); lock sequence runs
// only when FSM_RR_ARBITER_LOCK_EN is defined.
module tb_fsm_rr_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned MH  = 4;
  localparam int unsigned IDW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req = '0;
`ifdef FSM_RR_ARBITER_LOCK_EN
  logic           lock = 1'b0;
`endif
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;

  fsm_rr_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
`ifdef FSM_RR_ARBITER_LOCK_EN
    .lock      (lock),
`endif
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           rst_first;
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] id;
    string          name;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [N-1:0] eg, input logic [IDW-1:0] eid);
    chk({nm, ".gnt"},   int'(gnt),       int'(eg));
    chk({nm, ".id"},    int'(gnt_id),    int'(eid));
    chk({nm, ".valid"}, int'(gnt_valid), (eg != '0) ? 1 : 0);
  endtask

  task automatic step(input logic [N-1:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b0;
    #1 chk_out("rst_async", '0, '0);
    @(posedge clk);
    #1 chk_out("rst_hold", '0, '0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic void add(input logic rf, input logic [N-1:0] r,
                              input logic [N-1:0] g, input logic [IDW-1:0] id,
                              input string nm);
    vec_t v;
    v.rst_first = rf;
    v.req       = r;
    v.gnt       = g;
    v.id        = id;
    v.name      = nm;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [N-1:0] prev;
    int           run;
    int           eid;

    // Reset held at t0 with every requester asserted
    req = 4'b1111;
    #1 chk_out("reset_t0", '0, '0);
    repeat (3) begin
      @(posedge clk);
      #1 chk_out("reset_held", '0, '0);
    end
    @(negedge clk);
    rst = 1'b1;

    // Round-robin with all requesting: 4-cycle grants, 2 zero cycles between
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 4; c++)
        add(1'b0, 4'b1111, N'(1) << (g % 4), IDW'(g % 4), $sformatf("rr_g%0d_c%0d", g, c));
      if (g < 4)
        for (int c = 0; c < 2; c++)
          add(1'b0, 4'b1111, '0, '0, $sformatf("rr_gap%0d_c%0d", g, c));
    end

    // Early release
    add(1'b1, 4'b0100, 4'b0100, 2'd2, "early_c0");
    add(1'b0, 4'b0100, 4'b0100, 2'd2, "early_c1");
    add(1'b0, 4'b0000, 4'b0000, 2'd0, "early_gap");
    add(1'b0, 4'b0000, 4'b0000, 2'd0, "early_idle");

    // Wrap past index 3, skip empty slots
    add(1'b1, 4'b1000, 4'b1000, 2'd3, "wrap_g3");
    add(1'b0, 4'b0000, 4'b0000, 2'd0, "wrap_rel");
    add(1'b0, 4'b1010, 4'b0000, 2'd0, "wrap_idle");
    for (int c = 0; c < 4; c++)
      add(1'b0, 4'b1010, 4'b0010, 2'd1, $sformatf("wrap_g1_c%0d", c));
    add(1'b0, 4'b1010, 4'b0000, 2'd0, "wrap_gap");
    add(1'b0, 4'b1010, 4'b0000, 2'd0, "wrap_idle2");
    add(1'b0, 4'b1010, 4'b1000, 2'd3, "wrap_g3b_c0");
    add(1'b0, 4'b1010, 4'b1000, 2'd3, "wrap_g3b_c1");

    // Lone requester hits MAX_HOLD and is re-granted after the gap
    for (int c = 0; c < 4; c++)
      add(c == 0, 4'b0001, 4'b0001, 2'd0, $sformatf("lone_c%0d", c));
    add(1'b0, 4'b0001, 4'b0000, 2'd0, "lone_gap");
    add(1'b0, 4'b0001, 4'b0000, 2'd0, "lone_idle");
    add(1'b0, 4'b0001, 4'b0001, 2'd0, "lone_regrant");

    foreach (vecs[i]) begin
      if (vecs[i].rst_first) do_reset();
      step(vecs[i].req);
      chk_out(vecs[i].name, vecs[i].gnt, vecs[i].id);
    end

    // Async reset in the middle of a grant; pointer must return to N-1
    do_reset();
    step(4'b0100);
    chk_out("amid_grant", 4'b0100, 2'd2);
    #3 rst = 1'b0;
    #1 chk_out("amid_async", '0, '0);
    @(posedge clk);
    #1 chk_out("amid_held", '0, '0);
    @(negedge clk);
    rst = 1'b1;
    step(4'b1001);
    chk_out("amid_ptr", 4'b0001, 2'd0);
    step(4'b0000);
    chk_out("amid_rel", '0, '0);
    step(4'b0000);
    chk_out("amid_idle", '0, '0);
    step(4'b0100);
    chk_out("amid_regrant", 4'b0100, 2'd2);

`ifdef FSM_RR_ARBITER_LOCK_EN
    // Lock overrides MAX_HOLD; release on the first unlocked cycle at max
    do_reset();
    lock = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step(4'b0011);
      chk_out($sformatf("lock_c%0d", c), 4'b0001, 2'd0);
    end
    lock = 1'b0;
    step(4'b0011);
    chk_out("lock_rel", '0, '0);
    step(4'b0011);
    chk_out("lock_idle", '0, '0);
    step(4'b0011);
    chk_out("lock_next", 4'b0010, 2'd1);
`endif

    // Toggling requests: invariants every cycle
    do_reset();
    prev = '0;
    run  = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [N-1:0] r;
      r[0]   = ((cyc / 3) % 2) == 1;
      r[1]   = ((cyc / 4) % 2) == 1;
      r[3:2] = 2'($urandom);
      step(r);
      eid = 0;
      for (int b = 0; b < N; b++) if (gnt[b]) eid = b;
      run = (gnt != '0) ? ((gnt == prev) ? run + 1 : 1) : 0;
      prev = gnt;
      chk("rand_onehot", ($countones(gnt) <= 1) ? 1 : 0, 1);
      chk("rand_valid",  int'(gnt_valid), (gnt != '0) ? 1 : 0);
      chk("rand_id",     int'(gnt_id), eid);
      chk("rand_hold",   (run <= int'(MH)) ? 1 : 0, 1);
      chk("rand_known",  ($isunknown({gnt, gnt_valid, gnt_id})) ? 1 : 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
